// File: rtl/dac_spi_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_tx_if
// Brief    : Sample-path and SPI signal bundle for dac_spi_tx.
//            clip_cnt exists only when DACTX_CLIP_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface dac_spi_tx_if #(
    parameter int size = 19
);
    logic signed [size-1:0] y_in;
    logic                   en_out;
    logic                   sclk;
    logic                   mosi;
    logic                   sync_n;
    logic                   busy;
    logic                   overrun;
`ifdef DACTX_CLIP_CNT_EN
    logic [7:0]             clip_cnt;

    modport master (
        input  y_in,
        output en_out, sclk, mosi, sync_n, busy, overrun, clip_cnt
    );
    modport slave (
        output y_in,
        input  en_out, sclk, mosi, sync_n, busy, overrun, clip_cnt
    );
`else
    modport master (
        input  y_in,
        output en_out, sclk, mosi, sync_n, busy, overrun
    );
    modport slave (
        output y_in,
        input  en_out, sclk, mosi, sync_n, busy, overrun
    );
`endif
endinterface
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_tx
// Brief    : Sample-rate strobe, saturating offset-binary conversion and
//            16-bit MSB-first SPI DAC transmitter. Optional clip counter
//            enabled by defining DACTX_CLIP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dac_spi_tx #(
    parameter int size       = 19,
    parameter int pf         = 14,
    parameter int mag        = 4,
    parameter int DAC_BITS   = 12,
    parameter int CLK_DIV    = 2,
    parameter int SAMPLE_DIV = 100
) (
    input  wire logic      clk,
    input  wire logic      rst,
    dac_spi_tx_if.master   bus
);

    localparam int c_cnt_w = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int c_ph_w  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_sh    = pf + 1 - DAC_BITS;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SAMPLE_DIV - 1);
    localparam logic [c_ph_w-1:0]  c_ph_last  = c_ph_w'(CLK_DIV - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_load  = 2'd1;
    localparam logic [1:0] c_shift = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_ph_w-1:0]   r_ph;
    logic                r_low;
    logic [3:0]          r_bit;
    logic [15:0]         r_shreg;
    logic                r_overrun;

    logic                w_en;
    logic                w_ph_end;
    logic                w_ovf;
    logic [pf:0]         w_clip;
    logic [DAC_BITS-1:0] w_code;
    logic [15:0]         w_word;

    assign w_en     = (r_cnt == c_cnt_last);
    assign w_ph_end = (r_ph == c_ph_last);

    // In range exactly when the sign and all integer bits agree.
    assign w_ovf  = !((&bus.y_in[pf +: mag+1]) || (~|bus.y_in[pf +: mag+1]));
    assign w_clip = w_ovf ? {bus.y_in[size-1], {pf{~bus.y_in[size-1]}}}
                          : bus.y_in[pf:0];
    // Keeping the top DAC_BITS bits is the arithmetic shift; flipping the
    // sign bit adds the mid-scale offset.
    assign w_code = {~w_clip[pf], w_clip[pf-1 -: DAC_BITS-1]};
    assign w_word = 16'(w_code);

    generate
        if (c_sh > 0) begin : g_lsb_drop
            logic w_unused_lsb;
            assign w_unused_lsb = ^w_clip[c_sh-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (w_en) w_next = c_load;
            c_load:  w_next = c_shift;
            c_shift: if (w_ph_end && r_low && (r_bit == 4'd15)) w_next = c_done;
            c_done:  if (w_ph_end) w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    always_comb begin
        bus.busy   = (r_state != c_idle);
        bus.sync_n = (r_state != c_shift);
        bus.sclk   = !((r_state == c_shift) && r_low);
        bus.mosi   = (r_state == c_shift) ? r_shreg[15] : 1'b0;
    end

    assign bus.en_out  = w_en;
    assign bus.overrun = r_overrun;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_ph      <= '0;
            r_low     <= 1'b0;
            r_bit     <= 4'd0;
            r_shreg   <= 16'd0;
            r_overrun <= 1'b0;
        end else begin
            r_cnt <= w_en ? '0 : r_cnt + 1'b1;
            if (w_en && (r_state != c_idle)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                c_load: begin
                    r_shreg <= w_word;
                    r_ph    <= '0;
                    r_low   <= 1'b0;
                    r_bit   <= 4'd0;
                end
                c_shift: begin
                    if (w_ph_end) begin
                        r_ph <= '0;
                        // Next bit is presented together with the sclk rise.
                        if (r_low) begin
                            r_low   <= 1'b0;
                            r_bit   <= r_bit + 4'd1;
                            r_shreg <= {r_shreg[14:0], 1'b0};
                        end else begin
                            r_low <= 1'b1;
                        end
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                c_done: begin
                    r_ph <= w_ph_end ? '0 : r_ph + 1'b1;
                end
                default: begin
                    r_ph <= '0;
                end
            endcase
        end
    end

`ifdef DACTX_CLIP_CNT_EN
    logic [7:0] r_clip_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clip_cnt <= 8'd0;
        end else if ((r_state == c_load) && w_ovf && (r_clip_cnt != 8'hFF)) begin
            r_clip_cnt <= r_clip_cnt + 8'd1;
        end
    end

    assign bus.clip_cnt = r_clip_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_spi_tx
// Brief    : Directed self-checking bench for dac_spi_tx (default and
//            SAMPLE_DIV=40 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_spi_tx;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    always #5 clk = ~clk;

    dac_spi_tx_if #(.size(19)) if0 ();
    dac_spi_tx_if #(.size(19)) if1 ();

    dac_spi_tx u_dut0 (.clk(clk), .rst(rst0), .bus(if0));
    dac_spi_tx #(.SAMPLE_DIV(40)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1));

    int n_cmp = 0;
    int n_err = 0;

    // Frame monitor on the default instance; cycle numbers count from reset release.
    int          mon_cyc       = 0;
    bit          mon_in_fr     = 1'b0;
    int          mon_nf        = 0;
    int          mon_run       = 0;
    logic        mon_psclk     = 1'b1;
    logic        mon_pmosi     = 1'b0;
    logic [15:0] mon_sh        = 16'd0;
    int          first_en      = -1;
    int          fall_cyc      = -1;
    int          rise_cyc      = -1;
    int          busy_fall_cyc = -1;
    bit          busy_prev     = 1'b0;
    int          ph_err        = 0;
    int          stab_err      = 0;
    logic [15:0] words[$];
    int          falls[$];

    always @(negedge clk) begin
        if (!rst0) begin
            mon_cyc   = 0;
            mon_in_fr = 1'b0;
            busy_prev = 1'b0;
        end else begin
            mon_cyc = mon_cyc + 1;
            if (if0.en_out && first_en < 0) first_en = mon_cyc;
            if (!mon_in_fr) begin
                if (!if0.sync_n) begin
                    mon_in_fr = 1'b1;
                    fall_cyc  = mon_cyc;
                    mon_sh    = 16'd0;
                    mon_nf    = 0;
                    mon_run   = 1;
                    mon_psclk = if0.sclk;
                    mon_pmosi = if0.mosi;
                end
            end else if (if0.sync_n) begin
                mon_in_fr = 1'b0;
                rise_cyc  = mon_cyc;
                if (mon_run != 2) ph_err++;
                words.push_back(mon_sh);
                falls.push_back(mon_nf);
            end else begin
                if (if0.sclk != mon_psclk) begin
                    if (mon_run != 2) ph_err++;
                    mon_run = 1;
                end else begin
                    mon_run++;
                end
                if (mon_psclk && !if0.sclk) begin
                    mon_sh = {mon_sh[14:0], mon_pmosi};
                    mon_nf++;
                    if (if0.mosi !== mon_pmosi) stab_err++;
                end
                mon_psclk = if0.sclk;
                mon_pmosi = if0.mosi;
            end
            if (busy_prev && !if0.busy) busy_fall_cyc = mon_cyc;
            busy_prev = if0.busy;
        end
    end

    task automatic wait_word(output logic [15:0] w, output int nf);
        int n0 = words.size();
        int t  = 0;
        while (words.size() == n0 && t < 300) begin
            @(negedge clk); #1;
            t++;
        end
        if (words.size() == n0) begin
            n_cmp++; n_err++;
            $display("FAIL wait_word: no frame within 300 cycles (actual none, required one frame)");
            w  = 'x;
            nf = -1;
        end else begin
            w  = words[$];
            nf = falls[$];
        end
    endtask

    task automatic test_reset;
        rst0 = 1'b0;
        rst1 = 1'b0;
        if0.y_in = 19'sd0;
        if1.y_in = -19'sd1;
        repeat (3) @(negedge clk);
        n_cmp++; if (if0.en_out !== 1'b0) begin n_err++; $display("FAIL reset_en_out: got %b want 0", if0.en_out); end
        n_cmp++; if (if0.sclk !== 1'b1) begin n_err++; $display("FAIL reset_sclk: got %b want 1", if0.sclk); end
        n_cmp++; if (if0.mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", if0.mosi); end
        n_cmp++; if (if0.sync_n !== 1'b1) begin n_err++; $display("FAIL reset_sync_n: got %b want 1", if0.sync_n); end
        n_cmp++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", if0.busy); end
        n_cmp++; if (if0.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", if0.overrun); end
`ifdef DACTX_CLIP_CNT_EN
        n_cmp++; if (if0.clip_cnt !== 8'd0) begin n_err++; $display("FAIL reset_clip_cnt: got %0d want 0", if0.clip_cnt); end
`endif
        #1;
        rst0 = 1'b1;
        rst1 = 1'b1;
    endtask

    task automatic test_first_frame;
        logic [15:0] w;
        int nf;
        wait_word(w, nf);
        repeat (3) begin @(negedge clk); #1; end
        n_cmp++; if (first_en != 99) begin n_err++; $display("FAIL first_en_cycle: got %0d want 99", first_en); end
        n_cmp++; if (fall_cyc != 101) begin n_err++; $display("FAIL sync_fall_cycle: got %0d want 101", fall_cyc); end
        n_cmp++; if (rise_cyc != 165) begin n_err++; $display("FAIL sync_rise_cycle: got %0d want 165", rise_cyc); end
        n_cmp++; if (busy_fall_cyc != 167) begin n_err++; $display("FAIL busy_low_cycle: got %0d want 167", busy_fall_cyc); end
        n_cmp++; if (w !== 16'h0800) begin n_err++; $display("FAIL first_word: got %h want 0800", w); end
        n_cmp++; if (nf != 16) begin n_err++; $display("FAIL first_falls: got %0d want 16", nf); end
        n_cmp++; if (ph_err != 0) begin n_err++; $display("FAIL sclk_phase_len: got %0d bad phases want 0", ph_err); end
        n_cmp++; if (stab_err != 0) begin n_err++; $display("FAIL mosi_stable: got %0d unstable falls want 0", stab_err); end
    endtask

    task automatic test_codes;
        logic signed [18:0] vec [6] = '{19'sd16383, -19'sd16384, 19'sd8192, -19'sd1, 19'sd40000, -19'sd100000};
        logic [15:0]        exp [6] = '{16'h0FFF, 16'h0000, 16'h0C00, 16'h07FF, 16'h0FFF, 16'h0000};
`ifdef DACTX_CLIP_CNT_EN
        logic [7:0]         ecl [6] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
`endif
        logic [15:0] w;
        int nf;
        for (int i = 0; i < 6; i++) begin
            if0.y_in = vec[i];
            wait_word(w, nf);
            n_cmp++; if (w !== exp[i]) begin n_err++; $display("FAIL code_%0d: y=%0d got %h want %h", i, vec[i], w, exp[i]); end
            n_cmp++; if (nf != 16) begin n_err++; $display("FAIL code_falls_%0d: got %0d want 16", i, nf); end
`ifdef DACTX_CLIP_CNT_EN
            n_cmp++; if (if0.clip_cnt !== ecl[i]) begin n_err++; $display("FAIL clip_cnt_%0d: got %0d want %0d", i, if0.clip_cnt, ecl[i]); end
`endif
        end
        n_cmp++; if (ph_err != 0 || stab_err != 0) begin n_err++; $display("FAIL codes_timing: got %0d/%0d errors want 0/0", ph_err, stab_err); end
    endtask

    task automatic test_mid_frame;
        logic [15:0] w;
        int nf;
        int t = 0;
        if0.y_in = 19'sd8192;
        while (!mon_in_fr && t < 300) begin @(negedge clk); #1; t++; end
        n_cmp++; if (!mon_in_fr) begin n_err++; $display("FAIL mid_frame_start: got no frame want frame"); end
        if0.y_in = -19'sd16384;
        wait_word(w, nf);
        n_cmp++; if (w !== 16'h0C00) begin n_err++; $display("FAIL mid_frame_word: got %h want 0C00", w); end
        wait_word(w, nf);
        n_cmp++; if (w !== 16'h0000) begin n_err++; $display("FAIL after_mid_word: got %h want 0000", w); end
    endtask

    task automatic test_overrun;
        int  n_en = 0, last_en = -1, first_e = -1, gap_err = 0;
        int  n_fr = 0, first_fall = -1, ov_drop = 0;
        logic ov79 = 1'bx, ov80 = 1'bx;
        logic prev_sync = 1'b1;
        rst1 = 1'b0;
        @(negedge clk); #1;
        rst1 = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (if1.en_out) begin
                n_en++;
                if (last_en >= 0 && (k - last_en) != 40) gap_err++;
                if (first_e < 0) first_e = k;
                last_en = k;
            end
            if (prev_sync && !if1.sync_n) begin
                n_fr++;
                if (first_fall < 0) first_fall = k;
            end
            prev_sync = if1.sync_n;
            if (k == 79) ov79 = if1.overrun;
            if (k == 80) ov80 = if1.overrun;
            if (k >= 80 && if1.overrun !== 1'b1) ov_drop++;
        end
        n_cmp++; if (first_e != 39) begin n_err++; $display("FAIL ovr_first_en: got %0d want 39", first_e); end
        n_cmp++; if (n_en != 10) begin n_err++; $display("FAIL ovr_en_count: got %0d want 10", n_en); end
        n_cmp++; if (gap_err != 0) begin n_err++; $display("FAIL ovr_en_period: got %0d bad gaps want 0", gap_err); end
        n_cmp++; if (first_fall != 41) begin n_err++; $display("FAIL ovr_first_sync: got %0d want 41", first_fall); end
        n_cmp++; if (n_fr != 5) begin n_err++; $display("FAIL ovr_frames: got %0d want 5", n_fr); end
        n_cmp++; if (ov79 !== 1'b0) begin n_err++; $display("FAIL ovr_before: got %b want 0", ov79); end
        n_cmp++; if (ov80 !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", ov80); end
        n_cmp++; if (ov_drop != 0) begin n_err++; $display("FAIL ovr_sticky: got %0d low cycles want 0", ov_drop); end
        n_cmp++; if (if0.overrun !== 1'b0) begin n_err++; $display("FAIL dut0_no_overrun: got %b want 0", if0.overrun); end
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] w;
        int nf;
        int t = 0;
        if0.y_in = 19'sd16383;
        while (!(mon_in_fr && mon_nf == 7) && t < 300) begin @(negedge clk); #1; t++; end
        n_cmp++; if (if0.sync_n !== 1'b0) begin n_err++; $display("FAIL rst_mid_inframe: got sync_n=%b want 0", if0.sync_n); end
        #2;
        rst0 = 1'b0;
        #1;
        n_cmp++; if (if0.sclk !== 1'b1) begin n_err++; $display("FAIL rst_mid_sclk: got %b want 1", if0.sclk); end
        n_cmp++; if (if0.sync_n !== 1'b1) begin n_err++; $display("FAIL rst_mid_sync_n: got %b want 1", if0.sync_n); end
        n_cmp++; if (if0.mosi !== 1'b0) begin n_err++; $display("FAIL rst_mid_mosi: got %b want 0", if0.mosi); end
        n_cmp++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", if0.busy); end
        repeat (2) @(negedge clk);
        if0.y_in = -19'sd1;
        #1;
        rst0 = 1'b1;
        wait_word(w, nf);
        n_cmp++; if (w !== 16'h07FF) begin n_err++; $display("FAIL rst_next_word: got %h want 07FF", w); end
        n_cmp++; if (nf != 16) begin n_err++; $display("FAIL rst_next_falls: got %0d want 16", nf); end
        n_cmp++; if (fall_cyc != 101) begin n_err++; $display("FAIL rst_next_sync_fall: got %0d want 101", fall_cyc); end
    endtask

    initial begin
        test_reset;
        test_first_frame;
        test_codes;
        test_mid_frame;
        test_overrun;
        test_reset_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Output end of the biquad sample path.
- Generates the sample-rate enable (EN) that strobes the filter's registers.
- Captures the filter's fixed-point output y one cycle after each strobe, saturates it, and converts it to an offset-binary DAC code.
- Serialises the code MSB-first to an external SPI DAC (16-bit frame: 4 control zeros + 12 data bits).

Parameters:
- size, 19, total width of the incoming fixed-point sample (sign + mag + pf).
- pf, 14, fractional bits of the incoming sample.
- mag, 4, integer (magnitude) bits of the incoming sample.
- DAC_BITS, 12, DAC resolution; must satisfy DAC_BITS <= pf+1.
- CLK_DIV, 2, clk cycles per sclk half-period (>=1).
- SAMPLE_DIV, 100, clk cycles per sample period; must exceed 33*CLK_DIV+2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- y_in  in  size  signed filter output, Q(mag.pf) plus sign bit.
- en_out  out  1  one-cycle sample strobe, drives the filter EN.
- sclk  out  1  SPI clock, idle high.
- mosi  out  1  SPI data, MSB first.
- sync_n  out  1  frame select, active low.
- busy  out  1  high while a frame is in progress (capture through end of DONE).
- overrun  out  1  sticky; set when a strobe arrives while busy.

Behaviour:
- Reset (rst=0, asynchronous):
  - en_out=0, sclk=1, mosi=0, sync_n=1, busy=0, overrun=0.
  - Sample counter = 0; state = IDLE.
  - Reset asserted mid-frame aborts the frame immediately, with no partial-frame completion.
- Sample counter:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - en_out=1 for exactly the cycle in which count==SAMPLE_DIV-1 (cycle T).
  - First strobe occurs SAMPLE_DIV cycles after reset release.
- Capture (cycle T+1):
  - y_in is registered, because the filter output register updates on the T edge.
  - Clip raw y to [-2^pf, 2^pf-1].
  - s = clipped >>> (pf+1-DAC_BITS), arithmetic shift, truncation toward -inf.
  - code = s + 2^(DAC_BITS-1), as a DAC_BITS-bit unsigned value.
  - Frame word = {4'b0000, code} for DAC_BITS=12; in general, zero-pad the MSBs to 16 bits.
  - busy=1 from T+1.
- State machine: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
  - IDLE: waits for en_out.
  - LOAD: one cycle; conversion registered into the shift register.
  - SHIFT: starts at T+2.
    - sync_n=0.
    - For each of 16 bits: mosi presents the bit, sclk=1 for CLK_DIV cycles, then sclk=0 for CLK_DIV cycles. The DAC samples on the falling edge.
    - The next bit's mosi changes only on the sclk rising transition.
    - Duration: 32*CLK_DIV cycles.
  - DONE: sclk=1, sync_n=1, mosi=0 for CLK_DIV cycles, then IDLE with busy=0.
- Overrun rule:
  - An en_out strobe in any state other than IDLE is dropped (y not captured) and overrun is set.
  - overrun clears only on reset.
  - en_out itself is never suppressed; the filter keeps its rate.
- Mid-frame behaviour: y_in changing during SHIFT or DONE has no effect on the frame in progress.

Optional Feature:
- Macro: DACTX_CLIP_CNT_EN.
- Defined:
  - Adds output port clip_cnt [7:0], reset 0.
  - Increments by 1 on each capture where clipping altered the value.
  - Saturates at 255 and does not wrap.
- Undefined:
  - Port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, y_in=0, defaults: en_out first pulses at cycle 99. sync_n falls at cycle 101. Shifted word is 0x0800. sync_n rises at cycle 101+64=165. busy is low from cycle 167.
- y_in=+16383 (just below +1.0): word 0x0FFF. y_in=-16384: word 0x0000. y_in=8192 (+0.5): word 0x0C00. y_in=-1: word 0x07FF.
- y_in=+40000 and y_in=-100000 (out of range): words 0x0FFF and 0x0000. With DACTX_CLIP_CNT_EN, clip_cnt goes 0->1->2.
- Bit timing, CLK_DIV=2:
  - Each sclk high/low phase is 2 cycles.
  - mosi is stable across every sclk falling edge.
  - Exactly 16 falling edges occur while sync_n=0.
- SAMPLE_DIV=40 (< 68): second strobe falls during SHIFT. overrun=1 and stays 1. en_out keeps pulsing every 40 cycles. Only frames whose strobe landed in IDLE are transmitted.
- rst pulsed low at bit 7 of a frame: outputs return to reset values asynchronously. The next frame after the following strobe is complete and correct.
